// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared types for the SDRAM round-robin arbiter
package sdram_arb_pkg;

    localparam int CORE_DATA_W = 32;

    typedef enum logic {
        ARB   = 1'b0,
        ISSUE = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [3:0]             wr;
        logic                   rd;
        logic [7:0]             len;
        logic [31:0]            addr;
        logic [CORE_DATA_W-1:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic                   ack;
        logic                   error;
        logic [CORE_DATA_W-1:0] rdata;
    } rsp_t;

endpackage

// File: rtl/sdram_rr_arb_if.sv
// rtl/sdram_rr_arb_if.sv - master-side and core-side signal bundle of the arbiter
interface sdram_rr_arb_if #(
    parameter int NUM_PORTS       = 4,
    parameter int MAX_OUTSTANDING = 4
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    logic [NUM_PORTS*4-1:0]  port_wr_i;
    logic [NUM_PORTS-1:0]    port_rd_i;
    logic [NUM_PORTS*8-1:0]  port_len_i;
    logic [NUM_PORTS*32-1:0] port_addr_i;
    logic [NUM_PORTS*32-1:0] port_write_data_i;
    logic [NUM_PORTS-1:0]    port_accept_o;
    logic [NUM_PORTS-1:0]    port_ack_o;
    logic [NUM_PORTS-1:0]    port_error_o;
    logic [NUM_PORTS*32-1:0] port_read_data_o;
    logic [3:0]              core_wr_o;
    logic                    core_rd_o;
    logic [7:0]              core_len_o;
    logic [31:0]             core_addr_o;
    logic [31:0]             core_write_data_o;
    logic                    core_accept_i;
    logic                    core_ack_i;
    logic                    core_error_i;
    logic [31:0]             core_read_data_i;
    logic                    protocol_err_o;
    logic [CNT_W-1:0]        owner_count;

    modport slave (
        input  port_wr_i, port_rd_i, port_len_i, port_addr_i, port_write_data_i,
        input  core_accept_i, core_ack_i, core_error_i, core_read_data_i,
        output port_accept_o, port_ack_o, port_error_o, port_read_data_o,
        output core_wr_o, core_rd_o, core_len_o, core_addr_o, core_write_data_o,
        output protocol_err_o, owner_count
    );

    modport master (
        output port_wr_i, port_rd_i, port_len_i, port_addr_i, port_write_data_i,
        output core_accept_i, core_ack_i, core_error_i, core_read_data_i,
        input  port_accept_o, port_ack_o, port_error_o, port_read_data_o,
        input  core_wr_o, core_rd_o, core_len_o, core_addr_o, core_write_data_o,
        input  protocol_err_o, owner_count
    );
endinterface

// File: rtl/sdram_owner_fifo.sv
// rtl/sdram_owner_fifo.sv - in-order FIFO of port indices owning outstanding core commands
module sdram_owner_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 2,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push,
    input  logic [W-1:0]   din,
    input  logic           pop,
    output logic [W-1:0]   dout,
    output logic           full,
    output logic           empty,
    output logic [PTR_W:0] count
);
    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/sdram_rr_arb.sv
// rtl/sdram_rr_arb.sv - round-robin arbiter sharing one sdram_core_32bit among N masters
module sdram_rr_arb
    import sdram_arb_pkg::*;
#(
    parameter int NUM_PORTS       = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int IDX_W           = $clog2(NUM_PORTS)
) (
    input logic           clk_i,
    input logic           rst_i,
    sdram_rr_arb_if.slave bus
);
    arb_state_t                state, state_n;
    logic [IDX_W-1:0]          grant_idx, grant_n, last_idx, last_n;
    logic [IDX_W-1:0]          sel_idx, head;
    logic                      sel_found, push, pop, full, empty, perr;
    logic [NUM_PORTS-1:0]      req, accept, ack, err;
    logic [NUM_PORTS*32-1:0]   rdata;
    cmd_t                      port_cmd [NUM_PORTS];
    cmd_t                      core_cmd;
    rsp_t                      core_rsp;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign port_cmd[p] = {bus.port_wr_i[4*p +: 4], bus.port_rd_i[p], bus.port_len_i[8*p +: 8],
                              bus.port_addr_i[32*p +: 32], bus.port_write_data_i[32*p +: 32]};
        assign req[p]      = (|bus.port_wr_i[4*p +: 4]) | bus.port_rd_i[p];
    end

    // Scan starts one past the last served port so every requester waits at most N-1 grants.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            if (!sel_found && req[IDX_W'((int'(last_idx) + i) % NUM_PORTS)]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'((int'(last_idx) + i) % NUM_PORTS);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ARB;
            grant_idx <= '0;
            last_idx  <= IDX_W'(NUM_PORTS - 1);
        end else begin
            state     <= state_n;
            grant_idx <= grant_n;
            last_idx  <= last_n;
        end
    end

    always_comb begin
        state_n  = state;
        grant_n  = grant_idx;
        last_n   = last_idx;
        core_cmd = '0;
        push     = 1'b0;
        accept   = '0;
        case (state)
            ARB: begin
                if (sel_found) begin
                    grant_n = sel_idx;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                core_cmd = port_cmd[grant_idx];
                // A full owner FIFO has no slot to record this command's owner.
                if (full) begin
                    core_cmd.wr = '0;
                    core_cmd.rd = 1'b0;
                end
                if (bus.core_accept_i && ((|core_cmd.wr) || core_cmd.rd)) begin
                    push              = 1'b1;
                    accept[grant_idx] = 1'b1;
                    last_n            = grant_idx;
                    state_n           = ARB;
                end
            end
            default: state_n = ARB;
        endcase
    end

    sdram_owner_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .W     (IDX_W)
    ) u_owner_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (push),
        .din   (grant_idx),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (bus.owner_count)
    );

    assign core_rsp = '{ack: bus.core_ack_i, error: bus.core_error_i, rdata: bus.core_read_data_i};
    assign pop      = core_rsp.ack && !empty;

    always_comb begin
        ack   = '0;
        err   = '0;
        rdata = '0;
        if (pop) begin
            ack[head] = 1'b1;
            err[head] = core_rsp.error;
            rdata[CORE_DATA_W*int'(head) +: CORE_DATA_W] = core_rsp.rdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perr <= 1'b0;
        end else if (core_rsp.ack && empty) begin
            perr <= 1'b1;
        end
    end

    assign bus.port_accept_o     = accept;
    assign bus.port_ack_o        = ack;
    assign bus.port_error_o      = err;
    assign bus.port_read_data_o  = rdata;
    assign bus.core_wr_o         = core_cmd.wr;
    assign bus.core_rd_o         = core_cmd.rd;
    assign bus.core_len_o        = core_cmd.len;
    assign bus.core_addr_o       = core_cmd.addr;
    assign bus.core_write_data_o = core_cmd.wdata;
    assign bus.protocol_err_o    = perr;
endmodule

// File: tb/tb_sdram_rr_arb.sv
// tb/tb_sdram_rr_arb.sv - directed self-checking bench for sdram_rr_arb
module tb_sdram_rr_arb;
    logic       clk = 1'b0;
    logic       rst;
    int         tests  = 0;
    int         failed = 0;
    logic [3:0] oh;

    always #5 clk = ~clk;

    sdram_rr_arb_if #(.NUM_PORTS(4), .MAX_OUTSTANDING(4)) bus ();

    sdram_rr_arb #(
        .NUM_PORTS       (4),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_port(input int p, input logic [3:0] wr, input logic rd,
                            input logic [31:0] addr, input logic [31:0] wd);
        bus.port_wr_i[4*p +: 4]          = wr;
        bus.port_rd_i[p]                 = rd;
        bus.port_len_i[8*p +: 8]         = 8'(p + 1);
        bus.port_addr_i[32*p +: 32]      = addr;
        bus.port_write_data_i[32*p +: 32] = wd;
    endtask

    task automatic all_read();
        for (int p = 0; p < 4; p++) set_port(p, 4'h0, 1'b1, 32'h1000 * (p + 1), 32'h0);
    endtask

    task automatic clear_all();
        for (int p = 0; p < 4; p++) set_port(p, 4'h0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        clear_all();
        bus.core_accept_i    = 1'b0;
        bus.core_ack_i       = 1'b0;
        bus.core_error_i     = 1'b0;
        bus.core_read_data_i = 32'h0;
        tick();
        tick();
        settle();
        chk("rst_core_rd", bus.core_rd_o, 0);
        chk("rst_accept", bus.port_accept_o, 0);
        chk("rst_perr", bus.protocol_err_o, 0);
        chk("rst_count", bus.owner_count, 0);
        rst = 1'b0;
        bus.core_accept_i = 1'b1;

        // single port write then read on port 2
        set_port(2, 4'hF, 1'b0, 32'h100, 32'hDEADBEEF);
        settle();
        chk("t1_arb_idle_wr", bus.core_wr_o, 0);
        tick();
        settle();
        chk("t1_core_wr", bus.core_wr_o, 4'hF);
        chk("t1_core_addr", bus.core_addr_o, 32'h100);
        chk("t1_core_wdata", bus.core_write_data_o, 32'hDEADBEEF);
        chk("t1_core_len", bus.core_len_o, 8'd3);
        chk("t1_accept", bus.port_accept_o, 4'b0100);
        tick();
        set_port(2, 4'h0, 1'b0, 32'h0, 32'h0);
        settle();
        chk("t1_count_after_wr", bus.owner_count, 1);
        chk("t1_accept_idle", bus.port_accept_o, 0);
        bus.core_ack_i = 1'b1;
        settle();
        chk("t1_wr_ack", bus.port_ack_o, 4'b0100);
        tick();
        bus.core_ack_i = 1'b0;
        set_port(2, 4'h0, 1'b1, 32'h100, 32'h0);
        tick();
        settle();
        chk("t1_core_rd", bus.core_rd_o, 1);
        chk("t1_rd_accept", bus.port_accept_o, 4'b0100);
        tick();
        set_port(2, 4'h0, 1'b0, 32'h0, 32'h0);
        bus.core_ack_i       = 1'b1;
        bus.core_error_i     = 1'b1;
        bus.core_read_data_i = 32'hDEADBEEF;
        settle();
        chk("t1_rd_ack", bus.port_ack_o, 4'b0100);
        chk("t1_rd_data", bus.port_read_data_o, {32'h0, 32'hDEADBEEF, 64'h0});
        chk("t1_rd_error", bus.port_error_o, 4'b0100);
        tick();
        bus.core_ack_i       = 1'b0;
        bus.core_error_i     = 1'b0;
        bus.core_read_data_i = 32'h0;
        settle();
        chk("t1_count_drained", bus.owner_count, 0);

        // round robin with all four ports reading
        rst = 1'b1;
        tick();
        rst = 1'b0;
        all_read();
        for (int k = 0; k < 8; k++) begin
            oh = 4'b0001 << (k % 4);
            tick();
            bus.core_ack_i = 1'b0;
            settle();
            chk($sformatf("rr_accept_%0d", k), bus.port_accept_o, oh);
            chk($sformatf("rr_addr_%0d", k), bus.core_addr_o, 32'h1000 * ((k % 4) + 1));
            tick();
            bus.core_ack_i = 1'b1;
            settle();
            chk($sformatf("rr_ack_%0d", k), bus.port_ack_o, oh);
        end
        clear_all();
        tick();
        bus.core_ack_i = 1'b0;
        settle();
        chk("rr_count_drained", bus.owner_count, 0);

        // fifo full holds off the fifth command
        all_read();
        for (int k = 0; k < 4; k++) begin
            oh = 4'b0001 << k;
            tick();
            settle();
            chk($sformatf("full_accept_%0d", k), bus.port_accept_o, oh);
            tick();
        end
        settle();
        chk("full_count4", bus.owner_count, 4);
        tick();
        settle();
        chk("full_rd_gated", bus.core_rd_o, 0);
        chk("full_no_accept", bus.port_accept_o, 0);
        tick();
        settle();
        chk("full_rd_gated_hold", bus.core_rd_o, 0);
        chk("full_count_hold", bus.owner_count, 4);
        bus.core_ack_i = 1'b1;
        settle();
        chk("full_ack_oldest", bus.port_ack_o, 4'b0001);
        tick();
        bus.core_ack_i = 1'b0;
        settle();
        chk("full_rd_released", bus.core_rd_o, 1);
        chk("full_accept5", bus.port_accept_o, 4'b0001);
        chk("full_count3", bus.owner_count, 3);
        tick();
        clear_all();
        settle();
        chk("full_count_refill", bus.owner_count, 4);

        // simultaneous push and pop with two outstanding
        bus.core_ack_i = 1'b1;
        settle();
        chk("sim_ack_p1", bus.port_ack_o, 4'b0010);
        tick();
        settle();
        chk("sim_ack_p2", bus.port_ack_o, 4'b0100);
        tick();
        bus.core_ack_i = 1'b0;
        settle();
        chk("sim_count2", bus.owner_count, 2);
        set_port(1, 4'h0, 1'b1, 32'h2000, 32'h0);
        tick();
        bus.core_ack_i = 1'b1;
        settle();
        chk("sim_accept", bus.port_accept_o, 4'b0010);
        chk("sim_ack_oldest", bus.port_ack_o, 4'b1000);
        tick();
        bus.core_ack_i = 1'b0;
        set_port(1, 4'h0, 1'b0, 32'h0, 32'h0);
        settle();
        chk("sim_count_same", bus.owner_count, 2);

        // reset with three outstanding
        all_read();
        tick();
        settle();
        chk("mid_accept_p2", bus.port_accept_o, 4'b0100);
        tick();
        tick();
        rst = 1'b1;
        settle();
        chk("mid_accept_p3", bus.port_accept_o, 4'b1000);
        chk("mid_count3", bus.owner_count, 3);
        tick();
        rst = 1'b0;
        settle();
        chk("mid_rst_core_rd", bus.core_rd_o, 0);
        chk("mid_rst_core_addr", bus.core_addr_o, 0);
        chk("mid_rst_accept", bus.port_accept_o, 0);
        chk("mid_rst_ack", bus.port_ack_o, 0);
        chk("mid_rst_count", bus.owner_count, 0);
        chk("mid_rst_perr", bus.protocol_err_o, 0);
        tick();
        settle();
        chk("mid_first_grant_p0", bus.port_accept_o, 4'b0001);
        tick();
        clear_all();
        settle();
        chk("mid_count1", bus.owner_count, 1);

        // ack with nothing outstanding
        bus.core_ack_i = 1'b1;
        settle();
        chk("perr_last_ack", bus.port_ack_o, 4'b0001);
        tick();
        settle();
        chk("perr_no_port_ack", bus.port_ack_o, 0);
        chk("perr_not_yet", bus.protocol_err_o, 0);
        tick();
        bus.core_ack_i = 1'b0;
        settle();
        chk("perr_set", bus.protocol_err_o, 1);
        chk("perr_count0", bus.owner_count, 0);
        tick();
        tick();
        settle();
        chk("perr_sticky", bus.protocol_err_o, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        chk("perr_cleared", bus.protocol_err_o, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
